// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the BIST-facing SRAM fault model.
package sram_bist_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned MAX_ADDR_W = 32;
  localparam int unsigned MAX_BIT_W  = 8;

  localparam logic [1:0] FLT_SA0 = 2'd0;
  localparam logic [1:0] FLT_SA1 = 2'd1;
  localparam logic [1:0] FLT_TFU = 2'd2;
  localparam logic [1:0] FLT_TFD = 2'd3;

  // Fields are sized to the widest supported array so one type serves every instance.
  typedef struct packed {
    logic                  en;
    logic [1:0]            ftype;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_BIT_W-1:0]  bitpos;
  } flt_entry_t;

endpackage

// File: rtl/sram_fault_table.sv
// Programmable fault table; decodes per-bit fault masks for the word being accessed.
module sram_fault_table
  import sram_bist_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned NUM_FAULTS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned BIT_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flt_wr,
  input  logic [IDX_W-1:0]  flt_idx,
  input  logic              flt_en,
  input  logic [1:0]        flt_type,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [BIT_W-1:0]  flt_bit,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sa0_mask_c,
  output logic [DATA_W-1:0] sa1_mask_c,
  output logic [DATA_W-1:0] tfu_mask_c,
  output logic [DATA_W-1:0] tfd_mask_c
);

  flt_entry_t tbl_q [NUM_FAULTS];
  flt_entry_t tbl_d [NUM_FAULTS];

  // Indices beyond the table never match, so out-of-range writes fall away.
  always_comb begin
    tbl_d = tbl_q;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (flt_wr && (flt_idx == IDX_W'(i))) begin
        tbl_d[i] = '{en:     flt_en,
                     ftype:  flt_type,
                     addr:   MAX_ADDR_W'(flt_addr),
                     bitpos: MAX_BIT_W'(flt_bit)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FAULTS; i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // Ascending scan: a later matching entry overwrites the bit, so the highest index wins.
  always_comb begin
    sa0_mask_c = '0;
    sa1_mask_c = '0;
    tfu_mask_c = '0;
    tfd_mask_c = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (tbl_q[i].en && (tbl_q[i].addr == MAX_ADDR_W'(addr)) &&
            (tbl_q[i].bitpos == MAX_BIT_W'(b))) begin
          sa0_mask_c[b] = (tbl_q[i].ftype == FLT_SA0);
          sa1_mask_c[b] = (tbl_q[i].ftype == FLT_SA1);
          tfu_mask_c[b] = (tbl_q[i].ftype == FLT_TFU);
          tfd_mask_c[b] = (tbl_q[i].ftype == FLT_TFD);
        end
      end
    end
  end

endmodule

// File: rtl/sram_fault_model.sv
// Synchronous single-port SRAM with registered read and run-time stuck-at/transition fault injection.
module sram_fault_model
  import sram_bist_pkg::*;
#(
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned ADDR_W     = DEF_ADDR_W,
  parameter  int unsigned DEPTH      = 256,
  parameter  int unsigned NUM_FAULTS = 4,
  localparam int unsigned IDX_W      = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
  localparam int unsigned BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CE,
  input  logic              WE,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic              flt_wr,
  input  logic [IDX_W-1:0]  flt_idx,
  input  logic              flt_en,
  input  logic [1:0]        flt_type,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [BIT_W-1:0]  flt_bit
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;

  logic              in_range_c;
  logic [DATA_W-1:0] old_word_c, wr_word_c, rd_word_c;
  logic [DATA_W-1:0] sa0_mask_c, sa1_mask_c, tfu_mask_c, tfd_mask_c;

  sram_fault_table #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_FAULTS (NUM_FAULTS),
    .IDX_W      (IDX_W),
    .BIT_W      (BIT_W)
  ) u_fault_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .flt_wr     (flt_wr),
    .flt_idx    (flt_idx),
    .flt_en     (flt_en),
    .flt_type   (flt_type),
    .flt_addr   (flt_addr),
    .flt_bit    (flt_bit),
    .addr       (Address),
    .sa0_mask_c (sa0_mask_c),
    .sa1_mask_c (sa1_mask_c),
    .tfu_mask_c (tfu_mask_c),
    .tfd_mask_c (tfd_mask_c)
  );

  assign in_range_c = ({1'b0, Address} < (ADDR_W+1)'(DEPTH));
  assign old_word_c = in_range_c ? mem_q[MEM_AW'(Address)] : '0;

  // TF-up keeps a 0 cell at 0 on a rising write; TF-down keeps a 1 cell at 1 on a falling write.
  assign wr_word_c = (data_in & ~sa0_mask_c & ~(tfu_mask_c & ~old_word_c))
                   | sa1_mask_c | (tfd_mask_c & old_word_c);

  assign rd_word_c = in_range_c ? ((old_word_c & ~sa0_mask_c) | sa1_mask_c) : '0;

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && CE && WE && in_range_c) begin
      mem_q[MEM_AW'(Address)] <= wr_word_c;
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    if (CE && !WE) begin
      data_out_d = rd_word_c;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sram_fault_model.sv
// Randomised and directed bench for sram_fault_model against a word/bit-level reference model.
module tb_sram_fault_model;

  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam int unsigned NF    = 4;
  localparam int SA0 = 0, SA1 = 1, TFU = 2, TFD = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CE = 1'b0, WE = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          flt_wr = 1'b0;
  logic [1:0]    flt_idx = '0;
  logic          flt_en = 1'b0;
  logic [1:0]    flt_type = '0;
  logic [AW-1:0] flt_addr = '0;
  logic [1:0]    flt_bit = '0;

  sram_fault_model #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_FAULTS(NF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .CE(CE), .WE(WE), .Address(Address),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
    .flt_wr(flt_wr), .flt_idx(flt_idx), .flt_en(flt_en), .flt_type(flt_type),
    .flt_addr(flt_addr), .flt_bit(flt_bit)
  );

  always #5 clk = ~clk;

  // Reference model: stored bits plus a per-bit "value is defined" mask.
  logic [DW-1:0] m_mem   [256];
  logic [DW-1:0] m_known [256];
  logic          m_en [NF];
  int            m_ty [NF];
  logic [AW-1:0] m_ad [NF];
  int            m_bt [NF];

  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] exp_mask = '1;
  logic          exp_valid = 1'b0;
  bit            chk_en = 1'b0;
  int            total = 0;
  int            bad = 0;

  function automatic int fault_at(input logic [AW-1:0] a, input int b);
    for (int i = NF - 1; i >= 0; i--)
      if (m_en[i] && m_ad[i] == a && m_bt[i] == b) return m_ty[i];
    return -1;
  endfunction

  task automatic clear_table();
    for (int i = 0; i < NF; i++) begin
      m_en[i] = 1'b0; m_ty[i] = 0; m_ad[i] = '0; m_bt[i] = 0;
    end
  endtask

  task automatic check_lit(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (rd_valid !== exp_valid) begin
        bad++;
        $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, exp_valid, $time);
      end
      total++;
      if ((data_out & exp_mask) !== (exp_data & exp_mask)) begin
        bad++;
        $display("FAIL data_out: got %h expected %h (mask %h) at %0t",
                 data_out, exp_data, exp_mask, $time);
      end
    end
  end

  // One clock: drive inputs, predict outputs with the pre-edge table, then advance.
  task automatic cycle(input logic ce, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic fw, input logic [1:0] fi,
                       input logic fe, input int ft, input logic [AW-1:0] fa, input int fb);
    logic [DW-1:0] nd, nm, wv, wk;
    logic          nv, inr;
    int            f;
    CE = ce; WE = we; Address = a; data_in = d;
    flt_wr = fw; flt_idx = fi; flt_en = fe; flt_type = 2'(ft); flt_addr = fa; flt_bit = 2'(fb);
    nd = exp_data; nm = exp_mask; nv = 1'b0;
    inr = (int'(a) < DEPTH);
    if (ce && we && inr) begin
      for (int b = 0; b < DW; b++) begin
        f = fault_at(a, b);
        wv[b] = d[b]; wk[b] = 1'b1;
        if (f == SA0) wv[b] = 1'b0;
        else if (f == SA1) wv[b] = 1'b1;
        else if ((f == TFU && d[b]) || (f == TFD && !d[b])) begin
          wv[b] = m_mem[a][b]; wk[b] = m_known[a][b];
        end
      end
      m_mem[a] = wv; m_known[a] = wk;
    end else if (ce && !we) begin
      nv = 1'b1;
      if (!inr) begin
        nd = '0; nm = '1;
      end else begin
        for (int b = 0; b < DW; b++) begin
          f = fault_at(a, b);
          if (f == SA0)      begin nd[b] = 1'b0; nm[b] = 1'b1; end
          else if (f == SA1) begin nd[b] = 1'b1; nm[b] = 1'b1; end
          else               begin nd[b] = m_mem[a][b]; nm[b] = m_known[a][b]; end
        end
      end
    end
    if (fw) begin
      m_en[fi] = fe; m_ty[fi] = ft; m_ad[fi] = fa; m_bt[fi] = fb;
    end
    @(posedge clk);
    exp_data = nd; exp_mask = nm; exp_valid = nv;
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b0, 2'd0, 1'b0, 0, '0, 0);
  endtask
  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b1, 1'b0, a, '0, 1'b0, 2'd0, 1'b0, 0, '0, 0);
  endtask
  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 0, '0, 0);
  endtask
  task automatic fprog(input logic [1:0] i, input logic e, input int t,
                       input logic [AW-1:0] a, input int b);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, i, e, t, a, b);
  endtask

  initial begin
    logic [AW-1:0] ra;
    for (int i = 0; i < 256; i++) m_known[i] = '0;
    clear_table();

    repeat (2) @(posedge clk);
    #1;
    check_lit("reset_data", data_out, 4'h0);
    check_lit("reset_valid", {3'b0, rd_valid}, 4'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic write/read with an empty table.
    wr(8'h10, 4'hA);
    rd(8'h10);
    check_lit("basic_data", data_out, 4'hA);
    check_lit("basic_valid", {3'b0, rd_valid}, 4'h1);
    idle();
    check_lit("basic_pulse", {3'b0, rd_valid}, 4'h0);

    // Stuck-at-1 is stored on write and persists after the entry is disabled.
    fprog(2'd0, 1'b1, SA1, 8'h20, 2);
    wr(8'h20, 4'h0);
    rd(8'h20);
    check_lit("sa1_read", data_out, 4'h4);
    fprog(2'd0, 1'b0, SA1, 8'h20, 2);
    rd(8'h20);
    check_lit("sa1_stored", data_out, 4'h4);
    wr(8'h20, 4'h0);
    rd(8'h20);
    check_lit("sa1_cleared", data_out, 4'h0);

    // Transition faults.
    fprog(2'd1, 1'b1, TFU, 8'h30, 0);
    wr(8'h30, 4'h0);
    wr(8'h30, 4'h1);
    rd(8'h30);
    check_lit("tf_up", data_out, 4'h0);
    fprog(2'd2, 1'b1, TFD, 8'h31, 3);
    wr(8'h31, 4'hF);
    wr(8'h31, 4'h0);
    rd(8'h31);
    check_lit("tf_down", data_out, 4'h8);

    // Conflicting entries on one bit: higher index (SA1) wins.
    fprog(2'd1, 1'b1, SA0, 8'h40, 1);
    fprog(2'd3, 1'b1, SA1, 8'h40, 1);
    wr(8'h40, 4'h0);
    rd(8'h40);
    check_lit("priority", data_out, 4'h2);

    // Table write in the same cycle as an array write: the write sees the old table.
    cycle(1'b1, 1'b1, 8'h50, 4'h1, 1'b1, 2'd2, 1'b1, SA0, 8'h50, 0);
    rd(8'h50);
    check_lit("same_cycle_rdsa0", data_out, 4'h0);

    // Out-of-range addresses.
    wr(8'd220, 4'hF);
    rd(8'd220);
    check_lit("oor_data", data_out, 4'h0);
    check_lit("oor_valid", {3'b0, rd_valid}, 4'h1);

    // Asynchronous reset during a pending read.
    rd(8'h10);
    CE = 1'b1; WE = 1'b0; Address = 8'h10;
    #2;
    rst_n = 1'b0;
    exp_data = '0; exp_mask = '1; exp_valid = 1'b0;
    clear_table();
    #1;
    check_lit("arst_data", data_out, 4'h0);
    check_lit("arst_valid", {3'b0, rd_valid}, 4'h0);
    @(posedge clk);
    #1;
    CE = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_lit("arst_no_valid", {3'b0, rd_valid}, 4'h0);
    idle();
    idle();
    rd(8'h10);
    check_lit("arst_mem_kept", data_out, 4'hA);
    rd(8'h50);
    check_lit("arst_table_clr", data_out, 4'h1);

    // Randomised traffic over a small in-range window plus out-of-range addresses.
    for (int n = 0; n < 600; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      ra = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(DEPTH, 255))
                                       : 8'($urandom_range(0, 15));
      if (op < 4)
        wr(ra, 4'($urandom));
      else if (op < 8)
        rd(ra);
      else if (op == 8)
        fprog(2'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              8'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      else
        cycle(1'b1, 1'($urandom), ra, 4'($urandom), 1'b1, 2'($urandom), 1'b1,
              int'($urandom_range(0, 3)), ra, int'($urandom_range(0, 3)));
    end
    idle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_fault_model.md
Name: sram_fault_model

Overview:
- Parametrised, synchronous single-port SRAM model with a programmable fault-injection table.
- Successor to the fixed 256x4 combinational SRAM: registered read, chip enable, configurable width and depth.
- Injects stuck-at and transition faults at run time so the March LR BIST controller can be proven to detect them.
- Sits directly under the BIST controller; it is a verification and emulation target, not a synthesis macro.

Parameters:
- DATA_W, 4, data word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; must be <= 2**ADDR_W.
- NUM_FAULTS, 4, number of fault-table entries (1..16).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- CE  in  1  chip enable; no array access when low.
- WE  in  1  1 = write, 0 = read (qualified by CE).
- Address  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  high for one cycle when data_out carries new read data.
- flt_wr  in  1  write one fault-table entry this cycle.
- flt_idx  in  clog2(NUM_FAULTS), min 1  entry index.
- flt_en  in  1  entry enable.
- flt_type  in  2  0 = SA0, 1 = SA1, 2 = TF-up (0->1 fails), 3 = TF-down (1->0 fails).
- flt_addr  in  ADDR_W  faulty word address.
- flt_bit  in  clog2(DATA_W), min 1  faulty bit position.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: data_out = 0, rd_valid = 0, every fault entry disabled with all fields 0. Array contents are NOT reset and survive reset.
- Write (CE=1, WE=1, Address < DEPTH) at posedge: mem[Address] <= faulted(data_in). data_out holds its value; rd_valid = 0 next cycle.
- Read (CE=1, WE=0): on the next posedge data_out = read_faulted(mem[Address]) and rd_valid = 1. Latency is exactly 1 cycle; back-to-back reads give one result per cycle.
- Idle (CE=0): no array change; data_out holds; rd_valid = 0.
- Address >= DEPTH: writes are dropped; reads return 0 with rd_valid = 1.
- Write fault application, per bit b of the target word, using enabled entries whose flt_addr equals Address and flt_bit equals b:
  - SA0 forces 0; SA1 forces 1.
  - TF-up: if old bit = 0 and new bit = 1, the stored bit stays 0.
  - TF-down: if old bit = 1 and new bit = 0, the stored bit stays 1.
- Read fault application: SA0/SA1 entries also force the returned bit, so a stuck cell reads stuck even if never written. TF entries do not affect reads.
- Conflicting entries on the same bit: the highest enabled index wins.
- Fault-table writes:
  - flt_wr at posedge updates entry flt_idx; the new entry takes effect from the next cycle.
  - An array access in the same cycle uses the old table.
  - flt_idx >= NUM_FAULTS is ignored.
- Reset asserted mid-read: data_out and rd_valid clear immediately (asynchronous). The pending read is lost; no rd_valid after reset releases.
- Uninitialised words read X in simulation. The bench must write before checking, except at SA-faulted bits.

Decomposition:
- Package sram_bist_pkg:
  - Fault-type constants FLT_SA0, FLT_SA1, FLT_TFU, FLT_TFD.
  - Fault-entry struct {en, type, addr, bit}.
  - Shared DATA_W / ADDR_W defaults.
- Sub-module sram_fault_table:
  - Holds NUM_FAULTS entries and handles flt_wr and reset.
  - Combinationally produces per-bit sa0_mask, sa1_mask, tfu_mask, tfd_mask for the current Address.
- Top level owns the array, the read register and the mask application.

Test Plan:
- Reset, then with an empty table write 0xA to addr 0x10 and read it back -> data_out = 0xA one cycle after the read request, rd_valid pulses once.
- Program entry 0 as SA1, addr 0x20, bit 2; write 0x0 to 0x20 and read -> 0x4. Disable the entry and read again -> 0x4 is still stored; write 0x0 again and read -> 0x0.
- Program TF-up at addr 0x30, bit 0; write 0x0 then 0x1 and read -> 0x0. Program TF-down on bit 3 of a different word; write 0xF then 0x0 and read -> 0x8.
- Program entry 1 SA0 and entry 3 SA1, both at addr 0x40 bit 1; write 0x0 and read -> 0x2 (highest index wins).
- Issue flt_wr SA0 (addr 0x50, bit 0) in the same cycle as a write of 0x1 to 0x50; read -> 0x1 is stored, but a later read returns 0x0 because the read-side SA applies.
- Assert rst_n low for 1 cycle during a pending read -> data_out = 0 and rd_valid = 0 at once, no rd_valid after release. A previously written word still reads back correctly; the fault table is cleared.
